// File: rtl/score_pkg.sv
// Shared types and constants for the score segment scheduler: FSM states, slot counts,
// winner codes and the digit-to-segment mask lookup (bit 0 = segment a ... bit 6 = segment g).
package score_pkg;

    localparam int NUM_SLOTS      = 14;
    localparam int SEGS_PER_DIGIT = 7;

    localparam logic [1:0] WINNER_NONE  = 2'b00;
    localparam logic [1:0] WINNER_LEFT  = 2'b01;
    localparam logic [1:0] WINNER_RIGHT = 2'b10;
    localparam logic [1:0] WINNER_TIE   = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SNAP = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } sched_state_t;

    function automatic logic [6:0] digit_mask(input logic [3:0] digit);
        logic [6:0] mask;
        case (digit)
            4'd0:    mask = 7'h3F;
            4'd1:    mask = 7'h06;
            4'd2:    mask = 7'h5B;
            4'd3:    mask = 7'h4F;
            4'd4:    mask = 7'h66;
            4'd5:    mask = 7'h6D;
            4'd6:    mask = 7'h7D;
            4'd7:    mask = 7'h07;
            4'd8:    mask = 7'h7F;
            4'd9:    mask = 7'h6F;
            default: mask = 7'h00;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/score_seg_offset.sv
// Combinational segment geometry: segment number k within a digit plus digit centre -> bar centre and orientation.
// Zero latency; no handshake. All arithmetic wraps modulo 4096.
module score_seg_offset #(
    parameter int WIDTH  = 100,
    parameter int HEIGHT = 100
) (
    input  logic [2:0]  i_k,
    input  logic [11:0] i_cx,
    input  logic [11:0] i_cy,
    output logic [11:0] o_x,
    output logic [11:0] o_y,
    output logic        o_vert
);

    localparam logic [11:0] HW = 12'(WIDTH / 2);
    localparam logic [11:0] HH = 12'(HEIGHT / 2);
    localparam logic [11:0] HT = 12'(HEIGHT);

    always_comb begin
        o_x    = i_cx;
        o_y    = i_cy;
        o_vert = 1'b0;
        case (i_k)
            3'd0: o_y = i_cy - HT;
            3'd1: begin o_x = i_cx + HW; o_y = i_cy - HH; o_vert = 1'b1; end
            3'd2: begin o_x = i_cx + HW; o_y = i_cy + HH; o_vert = 1'b1; end
            3'd3: o_y = i_cy + HT;
            3'd4: begin o_x = i_cx - HW; o_y = i_cy + HH; o_vert = 1'b1; end
            3'd5: begin o_x = i_cx - HW; o_y = i_cy - HH; o_vert = 1'b1; end
            default: ;
        endcase
    end

endmodule

// File: rtl/score_segment_scheduler.sv
// Score keeper + per-frame 14-slot segment emitter; first seg_valid 2 cycles after frame_start, descriptors held stable under !seg_ready.
// Optional SCORE_BLINK_EN: blinks the winning digit(s) with a 16-frame phase.
module score_segment_scheduler
    import score_pkg::*;
#(
    parameter int WIDTH     = 100,
    parameter int HEIGHT    = 100,
    parameter int LEFT_X    = 200,
    parameter int RIGHT_X   = 600,
    parameter int DIGIT_Y   = 120,
    parameter int WIN_SCORE = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        point_l,
    input  logic        point_r,
    input  logic        new_game,
    input  logic        frame_start,
    output logic        seg_valid,
    input  logic        seg_ready,
    output logic [3:0]  seg_idx,
    output logic [11:0] seg_x,
    output logic [11:0] seg_y,
    output logic        seg_vert,
    output logic        seg_on,
    output logic        frame_done,
    output logic [3:0]  score_l,
    output logic [3:0]  score_r,
    output logic [1:0]  winner
);

    localparam logic [3:0]  WIN4      = 4'(WIN_SCORE);
    localparam logic [3:0]  LAST_SLOT = 4'(NUM_SLOTS - 1);
    localparam logic [3:0]  FIRST_R   = 4'(SEGS_PER_DIGIT);
    localparam logic [11:0] LX        = 12'(LEFT_X);
    localparam logic [11:0] RX        = 12'(RIGHT_X);
    localparam logic [11:0] DY        = 12'(DIGIT_Y);

    logic [3:0]   r_score_l, r_score_r;
    logic [1:0]   r_winner;
    sched_state_t r_state;
    logic [3:0]   r_slot;
    logic [3:0]   r_snap_l, r_snap_r;
    logic         r_seg_valid;
    logic         r_frame_done;

    logic [3:0]   w_next_l, w_next_r;
    logic         w_accept;
    logic         w_right;
    logic [2:0]   w_k;
    logic [11:0]  w_cx;
    logic [11:0]  w_off_x, w_off_y;
    logic         w_off_vert;
    logic [6:0]   w_mask;
    logic         w_blank;

    assign w_next_l = r_score_l + {3'b000, point_l};
    assign w_next_r = r_score_r + {3'b000, point_r};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_score_l <= 4'd0;
            r_score_r <= 4'd0;
            r_winner  <= WINNER_NONE;
        end else if (new_game) begin
            r_score_l <= 4'd0;
            r_score_r <= 4'd0;
            r_winner  <= WINNER_NONE;
        end else if (r_winner == WINNER_NONE) begin
            r_score_l <= w_next_l;
            r_score_r <= w_next_r;
            r_winner  <= {w_next_r == WIN4, w_next_l == WIN4};
        end
    end

    assign w_accept = r_seg_valid & seg_ready;

`ifdef SCORE_BLINK_EN
    logic [4:0] r_frame_cnt;
    logic [1:0] r_snap_win;

    // Bit 4 of the completed-frame count is the blink phase: 16 frames shown, 16 blanked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_cnt <= 5'd0;
            r_snap_win  <= WINNER_NONE;
        end else begin
            if (r_state == SNAP) r_snap_win <= r_winner;
            if (r_state == DONE) r_frame_cnt <= r_frame_cnt + 5'd1;
        end
    end

    assign w_blank = r_frame_cnt[4] & (w_right ? r_snap_win[1] : r_snap_win[0]);
`else
    assign w_blank = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_slot       <= 4'd0;
            r_snap_l     <= 4'd0;
            r_snap_r     <= 4'd0;
            r_seg_valid  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (frame_start) r_state <= SNAP;
                SNAP: begin
                    r_snap_l    <= r_score_l;
                    r_snap_r    <= r_score_r;
                    r_slot      <= 4'd0;
                    r_seg_valid <= 1'b1;
                    r_state     <= EMIT;
                end
                EMIT: if (w_accept) begin
                    if (r_slot == LAST_SLOT) begin
                        r_slot       <= 4'd0;
                        r_seg_valid  <= 1'b0;
                        r_frame_done <= 1'b1;
                        r_state      <= DONE;
                    end else begin
                        r_slot <= r_slot + 4'd1;
                    end
                end
                DONE: begin
                    r_frame_done <= 1'b0;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Descriptor fields derive only from registered slot/snapshot, so they cannot move during a stall.
    assign w_right = (r_slot >= FIRST_R);
    assign w_k     = w_right ? 3'(r_slot - FIRST_R) : r_slot[2:0];
    assign w_cx    = w_right ? RX : LX;
    assign w_mask  = digit_mask(w_right ? r_snap_r : r_snap_l);

    score_seg_offset #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_offset (
        .i_k    (w_k),
        .i_cx   (w_cx),
        .i_cy   (DY),
        .o_x    (w_off_x),
        .o_y    (w_off_y),
        .o_vert (w_off_vert)
    );

    assign seg_valid  = r_seg_valid;
    assign seg_idx    = r_seg_valid ? r_slot : 4'd0;
    assign seg_x      = r_seg_valid ? w_off_x : 12'd0;
    assign seg_y      = r_seg_valid ? w_off_y : 12'd0;
    assign seg_vert   = r_seg_valid & w_off_vert;
    assign seg_on     = r_seg_valid & w_mask[w_k] & ~w_blank;
    assign frame_done = r_frame_done;
    assign score_l    = r_score_l;
    assign score_r    = r_score_r;
    assign winner     = r_winner;

endmodule

// File: tb/tb_score_segment_scheduler.sv
// Randomized bench for score_segment_scheduler against a behavioural score/segment model.
`timescale 1ns/1ps
module tb_score_segment_scheduler;

    localparam int WIDTH = 100, HEIGHT = 100, LEFT_X = 200, RIGHT_X = 600, DIGIT_Y = 120, WIN_SCORE = 7;

    logic        clk = 1'b0;
    logic        rst, point_l, point_r, new_game, frame_start, seg_ready;
    logic        seg_valid, seg_vert, seg_on, frame_done;
    logic [3:0]  seg_idx, score_l, score_r;
    logic [11:0] seg_x, seg_y;
    logic [1:0]  winner;

    always #5 clk = ~clk;

    score_segment_scheduler #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .LEFT_X(LEFT_X), .RIGHT_X(RIGHT_X),
        .DIGIT_Y(DIGIT_Y), .WIN_SCORE(WIN_SCORE)
    ) dut (
        .clk(clk), .rst(rst), .point_l(point_l), .point_r(point_r), .new_game(new_game),
        .frame_start(frame_start), .seg_valid(seg_valid), .seg_ready(seg_ready),
        .seg_idx(seg_idx), .seg_x(seg_x), .seg_y(seg_y), .seg_vert(seg_vert), .seg_on(seg_on),
        .frame_done(frame_done), .score_l(score_l), .score_r(score_r), .winner(winner)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: scores, winner code, completed frames since reset.
    int m_l, m_r, m_win, m_frames;

    string lit_tbl[10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                           "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};
    int xoff[7] = '{0, WIDTH/2, WIDTH/2, 0, -WIDTH/2, -WIDTH/2, 0};
    int yoff[7] = '{-HEIGHT, -HEIGHT/2, HEIGHT/2, HEIGHT, HEIGHT/2, -HEIGHT/2, 0};

    function automatic bit seg_lit(input int d, input int k);
        string s = lit_tbl[d];
        for (int i = 0; i < s.len(); i++)
            if (s[i] == byte'(97 + k)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_point(input bit pl, input bit pr, input bit ng);
        if (ng) begin
            m_l = 0; m_r = 0; m_win = 0;
        end else if (m_win == 0) begin
            m_l += int'(pl);
            m_r += int'(pr);
            m_win = (m_l == WIN_SCORE ? 1 : 0) + (m_r == WIN_SCORE ? 2 : 0);
        end
    endfunction

    function automatic void model_reset();
        m_l = 0; m_r = 0; m_win = 0; m_frames = 0;
    endfunction

    task automatic check_scores();
        check("score_l", 32'(score_l), m_l);
        check("score_r", 32'(score_r), m_r);
        check("winner", 32'(winner), m_win);
    endtask

    task automatic pulse(input bit pl, input bit pr, input bit ng);
        point_l = pl; point_r = pr; new_game = ng;
        @(negedge clk);
        point_l = 0; point_r = 0; new_game = 0;
        model_point(pl, pr, ng);
        check_scores();
    endtask

    // One frame; stall_at/inj_r_at/fs_at < 0 disable the forced stall, mid-frame point_r and stray frame_start.
    task automatic run_frame(input int stall_pct, input int stall_at, input int inj_r_at, input int fs_at);
        int snap_l, snap_r, snap_w, phase, slot, cyc, held, k, cx, d;
        bit rdy, prev_stall, on;
        logic [3:0]  p_idx;
        logic [11:0] p_x, p_y;
        snap_l = m_l; snap_r = m_r; snap_w = m_win; phase = (m_frames / 16) % 2;
        slot = 0; held = 0; prev_stall = 0; p_idx = '0; p_x = '0; p_y = '0;
        frame_start = 1;
        @(negedge clk);
        frame_start = 0; cyc = 1;
        check("snap_no_valid", 32'(seg_valid), 0);
        @(negedge clk);
        cyc = 2;
        check("first_valid", 32'(seg_valid), 1);
        while (slot < 14 && cyc < 400) begin
            if (prev_stall) begin
                check($sformatf("hold_idx[%0d]", slot), 32'(seg_idx), 32'(p_idx));
                check($sformatf("hold_x[%0d]", slot), 32'(seg_x), 32'(p_x));
                check($sformatf("hold_y[%0d]", slot), 32'(seg_y), 32'(p_y));
            end
            if (!seg_valid) begin
                check($sformatf("valid_held[%0d]", slot), 32'(seg_valid), 1);
                break;
            end
            rdy = ($urandom_range(99) >= stall_pct);
            if (slot == stall_at && held < 5) begin rdy = 0; held++; end
            seg_ready = rdy;
            prev_stall = !rdy;
            p_idx = seg_idx; p_x = seg_x; p_y = seg_y;
            if (rdy) begin
                k  = slot % 7;
                cx = (slot < 7) ? LEFT_X : RIGHT_X;
                d  = (slot < 7) ? snap_l : snap_r;
                on = seg_lit(d, k);
`ifdef SCORE_BLINK_EN
                if (phase == 1 && ((snap_w >> ((slot < 7) ? 0 : 1)) & 1) == 1) on = 0;
`endif
                check("seg_idx", 32'(seg_idx), slot);
                check($sformatf("seg_x[%0d]", slot), 32'(seg_x), (cx + xoff[k]) & 4095);
                check($sformatf("seg_y[%0d]", slot), 32'(seg_y), (DIGIT_Y + yoff[k]) & 4095);
                check($sformatf("seg_vert[%0d]", slot), 32'(seg_vert), (k == 1 || k == 2 || k == 4 || k == 5) ? 1 : 0);
                check($sformatf("seg_on[%0d]", slot), 32'(seg_on), 32'(on));
                if (slot == inj_r_at) point_r = 1;
                if (slot == fs_at) frame_start = 1;
                slot++;
            end
            @(negedge clk);
            cyc++;
            frame_start = 0;
            if (point_r) begin
                point_r = 0;
                model_point(0, 1, 0);
                check("midframe_score_r", 32'(score_r), m_r);
            end
        end
        check("slots_emitted", slot, 14);
        if (stall_at >= 0) check("stall_cycles", held, 5);
        check("frame_done", 32'(frame_done), 1);
        if (stall_pct == 0 && stall_at < 0) check("done_latency", cyc, 16);
        seg_ready = 0;
        m_frames++;
        @(negedge clk);
        check("done_pulse_len", 32'(frame_done), 0);
        check("idle_valid", 32'(seg_valid), 0);
        @(negedge clk);
        check("stay_idle", 32'(seg_valid), 0);
    endtask

    initial begin
        int done_seen;
        rst = 1; point_l = 0; point_r = 0; new_game = 0; frame_start = 0; seg_ready = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("rst_seg_valid", 32'(seg_valid), 0);
        check("rst_seg_x", 32'(seg_x), 0);
        check("rst_seg_y", 32'(seg_y), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check_scores();
        rst = 0;
        @(negedge clk);

        // Clean frame at score 0/0, ready always high.
        run_frame(0, -1, -1, -1);

        // 3/1 then a frame with random backpressure.
        repeat (3) pulse(1, 0, 0);
        pulse(0, 1, 0);
        run_frame(30, -1, -1, -1);

        // Five-cycle stall on slot 4.
        run_frame(0, 4, -1, -1);

        // Point during EMIT: frame shows old digit, next frame the new one.
        run_frame(0, -1, 3, 6);
        run_frame(20, -1, -1, -1);

        // Tie at WIN_SCORE, points ignored afterwards, new_game wins over point.
        pulse(0, 0, 1);
        repeat (WIN_SCORE) pulse(1, 1, 0);
        pulse(1, 0, 0);
        run_frame(10, -1, -1, -1);
        pulse(1, 0, 1);

        // Random scoring and backpressure.
        for (int it = 0; it < 10; it++) begin
            int np = $urandom_range(3);
            for (int j = 0; j < np; j++)
                pulse(1'($urandom_range(1)), 1'($urandom_range(1)), ($urandom_range(9) == 0));
            run_frame($urandom_range(40), -1, ($urandom_range(3) == 0) ? int'($urandom_range(13)) : -1,
                      int'($urandom_range(13)));
        end

        // Reset mid-EMIT.
        frame_start = 1;
        @(negedge clk);
        frame_start = 0;
        seg_ready = 1;
        repeat (5) @(negedge clk);
        check("pre_rst_valid", 32'(seg_valid), 1);
        #2 rst = 1;
        #1 check("rst_async_valid", 32'(seg_valid), 0);
        @(negedge clk);
        rst = 0;
        seg_ready = 0;
        model_reset();
        check_scores();
        done_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (frame_done || seg_valid) done_seen++;
        end
        check("no_done_after_rst", done_seen, 0);
        run_frame(0, -1, -1, -1);

        // Left wins, then enough frames to cover both blink phases.
        repeat (WIN_SCORE) pulse(1, 0, 0);
        for (int f = 0; f < 33; f++) run_frame((f % 4 == 0) ? 25 : 0, -1, -1, -1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
